// File: rtl/display_pkg.sv
// Shared types, constants and the polarity helper for the multiplexed display scanner.
package display_pkg;

  localparam int   DEFAULT_SEG_W = 8;
  localparam logic SEG_OFF       = 1'b0;
  localparam logic SEG_ON        = 1'b1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Everything upstream of the pin registers is active-high; flip only here.
  function automatic logic [63:0] apply_polarity(input logic [63:0] value, input bit active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/display_scan_mux_scan_timer.sv
// Slot timer: counts 0..limit-1 for the current state and flags the last cycle of the slot.
module scan_timer
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  scan_state_e state_i,
  output logic        tick_o
);

  localparam int MAX_LIMIT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = (MAX_LIMIT > 1) ? $clog2(MAX_LIMIT) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d, last_val;

  // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    last_val = (state_i == ST_SHOW) ? SHOW_LAST : BLANK_LAST;
    tick_o   = (cnt_q == last_val);
    cnt_d    = tick_o ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_mux.sv
// Counter-driven scanner that time-multiplexes N_DIGITS digits onto one segment bus,
// with blank gaps, per-digit enable, frame-synchronous double buffering and output polarity.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SEG_W          = DEFAULT_SEG_W,
  parameter int DWELL_CYCLES   = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_DIGITS*SEG_W-1:0] digit_segs,
  input  logic [N_DIGITS-1:0]       digit_en,
  input  logic                      load,
  output logic [SEG_W-1:0]          seg_out,
  output logic [N_DIGITS-1:0]       dig_sel,
  output logic                      frame_done
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  // With no blank gap the scanner lives permanently in SHOW, starting from reset.
  localparam scan_state_e SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
  localparam logic [SEG_W-1:0]    SEG_IDLE = SEG_W'(apply_polarity(64'(0), SEG_ACTIVE_LOW));
  localparam logic [N_DIGITS-1:0] SEL_IDLE = N_DIGITS'(apply_polarity(64'(0), SEL_ACTIVE_LOW));

  typedef logic [N_DIGITS-1:0][SEG_W-1:0] seg_bank_t;

  scan_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  seg_bank_t           pend_segs_q, pend_segs_d, act_segs_q, act_segs_d;
  logic [N_DIGITS-1:0] pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic                frame_done_q;
  logic                slot_end, boundary, lit;
  logic [SEG_W-1:0]    seg_int;
  logic [N_DIGITS-1:0] sel_int;

  scan_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .state_i(state_q),
    .tick_o (slot_end)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    boundary = (state_q == ST_SHOW) && slot_end && (idx_q == LAST_IDX);

    if (slot_end) begin
      if (state_q == ST_BLANK) begin
        state_d = ST_SHOW;
      end else begin
        state_d = SLOT_START;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end

    // A load on the boundary cycle flows through pending straight into active.
    pend_segs_d = load ? seg_bank_t'(digit_segs) : pend_segs_q;
    pend_en_d   = load ? digit_en : pend_en_q;
    act_segs_d  = boundary ? pend_segs_d : act_segs_q;
    act_en_d    = boundary ? pend_en_d : act_en_q;

    lit     = (state_q == ST_SHOW) && act_en_q[idx_q];
    seg_int = lit ? act_segs_q[idx_q] : {SEG_W{SEG_OFF}};
    sel_int = lit ? (N_DIGITS'(SEG_ON) << idx_q) : '0;
    seg_d   = SEG_W'(apply_polarity(64'(seg_int), SEG_ACTIVE_LOW));
    sel_d   = N_DIGITS'(apply_polarity(64'(sel_int), SEL_ACTIVE_LOW));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SLOT_START;
      idx_q        <= '0;
      // NOTE: the display buffers are deliberately reset so a reset blanks the panel immediately.
      pend_segs_q  <= '0;
      pend_en_q    <= '0;
      act_segs_q   <= '0;
      act_en_q     <= '0;
      seg_q        <= SEG_IDLE;
      sel_q        <= SEL_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_segs_q  <= pend_segs_d;
      pend_en_q    <= pend_en_d;
      act_segs_q   <= act_segs_d;
      act_en_q     <= act_en_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= boundary;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = sel_q;
  assign frame_done = frame_done_q;

endmodule
